// File: rtl/jtag_types_pkg.sv
// jtag_types_pkg: shared JTAG IR opcodes, capture constants and opcode decode.
package jtag_types_pkg;
  localparam int unsigned IR_WIDTH_DEFAULT = 5;
  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;
  typedef enum logic [4:0] {
    EXTEST         = 5'h00,
    IDCODE         = 5'h01,
    SAMPLE_PRELOAD = 5'h02,
    AHB            = 5'h10,
    AHB_READ       = 5'h11,
    BYPASS         = 5'h1F
  } instruction_t;
  function automatic instruction_t decode_opcode(input logic [4:0] op);
    case (op)
      5'h00:   return EXTEST;
      5'h01:   return IDCODE;
      5'h02:   return SAMPLE_PRELOAD;
      5'h10:   return AHB;
      5'h11:   return AHB_READ;
      default: return BYPASS;
    endcase
  endfunction
endpackage

// File: rtl/jtag_instruction_register_if.sv
// jtag_instruction_register_if: TAP strobes in, IR serial output and decoded instruction out.
// master: TAP controller / output-logic side; slave: the instruction register.
interface jtag_instruction_register_if;
  import jtag_types_pkg::*;
  logic         TDI;
  logic         capture_ir;
  logic         shift_ir;
  logic         update_ir;
  logic         tlr_reset;
  logic         tmp_status;
  logic         instr_out;
  instruction_t instruction;
  logic         ahb;
  logic         ahb_read;
  logic         idcode;
  modport master (
    output TDI, capture_ir, shift_ir, update_ir, tlr_reset, tmp_status,
    input  instr_out, instruction, ahb, ahb_read, idcode
  );
  modport slave (
    input  TDI, capture_ir, shift_ir, update_ir, tlr_reset, tmp_status,
    output instr_out, instruction, ahb, ahb_read, idcode
  );
endinterface

// File: rtl/jtag_ir_decode.sv
// jtag_ir_decode: combinational latched-opcode decode to instruction and class flags.
// Ports: ir_i latched opcode; instruction_o, ahb_o, ahb_read_o, idcode_o decoded outputs.
module jtag_ir_decode
  import jtag_types_pkg::*;
#(
  parameter int unsigned W = IR_WIDTH_DEFAULT
) (
  input  logic [W-1:0] ir_i,
  output instruction_t instruction_o,
  output logic         ahb_o,
  output logic         ahb_read_o,
  output logic         idcode_o
);
  logic [31:0] op;
  // Opcodes wider than the 5-bit table can never match a known instruction.
  always_comb begin
    op            = 32'(ir_i);
    instruction_o = op > 32'h1F ? BYPASS : decode_opcode(op[4:0]);
    ahb_o         = instruction_o == AHB || instruction_o == AHB_READ;
    ahb_read_o    = instruction_o == AHB_READ;
    idcode_o      = instruction_o == IDCODE;
  end
endmodule

// File: rtl/jtag_instruction_register.sv
// jtag_instruction_register: JTAG IR capture/shift/update stage with opcode decode.
// Ports: TCK clock, TRST sync active-high reset, bus (slave) carrying TAP strobes,
// TDI/tmp_status in, and instr_out (sr bit 0) plus decoded instruction flags out.
module jtag_instruction_register
  import jtag_types_pkg::*;
#(
  parameter int unsigned IR_WIDTH     = IR_WIDTH_DEFAULT,
  parameter int unsigned CAPTURE_FILL = 0
) (
  input logic                          TCK,
  input logic                          TRST,
  jtag_instruction_register_if.slave   bus
);
  localparam logic [IR_WIDTH-1:0] FILL      = IR_WIDTH'(CAPTURE_FILL << 3);
  localparam logic [IR_WIDTH-1:0] IDCODE_OP = IR_WIDTH'(IDCODE);
  localparam logic [IR_WIDTH-1:0] RESET_CV  = FILL | IR_WIDTH'({1'b0, IR_CAPTURE_LSBS});
  logic [IR_WIDTH-1:0] sr_q, sr_d, ir_q, ir_d, cv;
  // Reset-class inputs dominate, then capture, shift, update; capture and
  // shift leave ir untouched so a half-shifted value can never be latched.
  always_comb begin
    cv   = FILL | IR_WIDTH'({bus.tmp_status, IR_CAPTURE_LSBS});
    sr_d = bus.tlr_reset ? RESET_CV
         : bus.capture_ir ? cv
         : bus.shift_ir ? {bus.TDI, sr_q[IR_WIDTH-1:1]}
         : sr_q;
    ir_d = bus.tlr_reset ? IDCODE_OP
         : (!bus.capture_ir && !bus.shift_ir && bus.update_ir) ? sr_q
         : ir_q;
  end
  always_ff @(posedge TCK) begin
    if (TRST) begin
      sr_q <= RESET_CV;
      ir_q <= IDCODE_OP;
    end else begin
      sr_q <= sr_d;
      ir_q <= ir_d;
    end
  end
  assign bus.instr_out = sr_q[0];
  jtag_ir_decode #(.W(IR_WIDTH)) u_decode (
    .ir_i          (ir_q),
    .instruction_o (bus.instruction),
    .ahb_o         (bus.ahb),
    .ahb_read_o    (bus.ahb_read),
    .idcode_o      (bus.idcode)
  );
endmodule
